// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register-file write-port arbiter.
//   DATA_W / ADDR_W / NREG : datapath and register-index sizing
//   REQ_ALU / REQ_LOAD     : requester indices (0 = ALU writeback, 1 = load/external)
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 2;
  localparam int NREG     = 1 << ADDR_W;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant with hold and a last-granted register.
//   clk, reset (async, active-low), hold : control
//   req[1:0]  : requests, index REQ_ALU / REQ_LOAD
//   gnt[1:0]  : combinational one-hot (or zero) grant
//   last_gnt  : index of the most recently granted requester
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       last_gnt
);
  logic last_gnt_q, last_gnt_d;
  logic en;
  // Under contention the requester that did not win last time takes the grant.
  always_comb begin
    en             = reset & ~hold;
    gnt            = '0;
    gnt[REQ_ALU]   = en & req[REQ_ALU]  & (~req[REQ_LOAD] |  last_gnt_q);
    gnt[REQ_LOAD]  = en & req[REQ_LOAD] & (~req[REQ_ALU]  | ~last_gnt_q);
    last_gnt_d     = gnt[REQ_ALU] ? 1'b0 : gnt[REQ_LOAD] ? 1'b1 : last_gnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_gnt_q <= 1'b1;
    else        last_gnt_q <= last_gnt_d;
  assign last_gnt = last_gnt_q;
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between two writeback requesters.
//   clk, reset (async, active-low), hold   : control
//   req0/addr0/data0 -> gnt0               : ALU writeback requester
//   req1/addr1/data1 -> gnt1               : load/external writeback requester
//   rf_write_reg/rf_write_data/rf_reg_write: registered issue stage to the register file
//   wr_pending                             : one-hot of the register being written
//   last_gnt                               : most recently granted requester
module regfile_wr_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   req0,
  input  logic [ADDR_W-1:0]      addr0,
  input  logic [DATA_W-1:0]      data0,
  output logic                   gnt0,
  input  logic                   req1,
  input  logic [ADDR_W-1:0]      addr1,
  input  logic [DATA_W-1:0]      data1,
  output logic                   gnt1,
  output logic [ADDR_W-1:0]      rf_write_reg,
  output logic [DATA_W-1:0]      rf_write_data,
  output logic                   rf_reg_write,
  output logic [(1<<ADDR_W)-1:0] wr_pending,
  output logic                   last_gnt
);
  import regfile_pkg::*;
  localparam int NREG = 1 << ADDR_W;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] rf_write_reg_q, rf_write_reg_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
  logic              rf_reg_write_q, rf_reg_write_d;
  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .req      ({req1, req0}),
    .gnt      (gnt),
    .last_gnt (last_gnt)
  );
  assign gnt0 = gnt[REQ_ALU];
  assign gnt1 = gnt[REQ_LOAD];
  // Address/data only follow the granted port, so an idle port's X never propagates.
  always_comb begin
    rf_reg_write_d  = gnt0 | gnt1;
    rf_write_reg_d  = gnt1 ? addr1 : gnt0 ? addr0 : rf_write_reg_q;
    rf_write_data_d = gnt1 ? data1 : gnt0 ? data0 : rf_write_data_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rf_reg_write_q  <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
    end else begin
      rf_reg_write_q  <= rf_reg_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
    end
  assign rf_reg_write  = rf_reg_write_q;
  assign rf_write_reg  = rf_write_reg_q;
  assign rf_write_data = rf_write_data_q;
  assign wr_pending    = rf_reg_write_q ? NREG'(1) << rf_write_reg_q : '0;
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 4-entry, 32-bit register file between two writeback requesters (req0 = ALU writeback, req1 = load/external writeback).
- Round-robin arbitration with a valid/grant handshake and one registered issue stage that drives WriteReg/WriteData/RegWrite of the register file.
- Exports a per-register pending mask so read-side logic can detect a write in flight.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 2, register index width; register count NREG = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- hold  input  1  when 1, no new grants; an already-issued write still completes.
- req0  input  1  requester 0 write request.
- addr0  input  ADDR_W  requester 0 destination register.
- data0  input  DATA_W  requester 0 write data.
- gnt0  output  1  requester 0 accepted this cycle (combinational).
- req1  input  1  requester 1 write request.
- addr1  input  ADDR_W  requester 1 destination register.
- data1  input  DATA_W  requester 1 write data.
- gnt1  output  1  requester 1 accepted this cycle (combinational).
- rf_write_reg  output  ADDR_W  to register file WriteReg.
- rf_write_data  output  DATA_W  to register file WriteData.
- rf_reg_write  output  1  to register file RegWrite.
- wr_pending  output  NREG  one-hot of register being written by the issue stage.
- last_gnt  output  1  requester most recently granted (debug/visibility).

Behaviour:
- Reset is asynchronous and active-low. While reset=0, all of the following hold:
  - rf_reg_write=0, rf_write_reg=0, rf_write_data=0, wr_pending=0.
  - last_gnt=1, so requester 0 has priority on the first contention.
  - gnt0 and gnt1 are forced to 0.
- Handshake:
  - A requester holds req, addr and data stable until it sees its gnt high at a rising edge.
  - Transfer occurs at an edge where req&gnt=1.
  - Dropping req before grant is legal; nothing is written.
- Grant logic (combinational):
  - No grant when hold=1.
  - Only one req high: that requester is granted.
  - Both high: the requester != last_gnt is granted.
  - gnt0 and gnt1 are never both 1.
- last_gnt updates on every accepted transfer to the index granted. Worst-case wait under contention is 1 cycle.
- Issue stage (registered):
  - On the accept edge N, rf_write_reg/rf_write_data load the winner's addr/data, rf_reg_write=1, and wr_pending=1<<addr.
  - If there is no accept at edge N, rf_reg_write=0 and wr_pending=0 in the next cycle. rf_write_reg/rf_write_data hold their last values.
  - The register file captures at edge N+1. Accept-to-architectural-write latency is 2 edges.
- Throughput: one write per cycle. Back-to-back accepts are legal with no bubble.
- Same-address contention:
  - Both requesters target the same register in the same cycle: writes are serialized in grant order.
  - The register's final value is the later-granted requester's data.
- hold asserted while a write is issued: the issued write completes and no new grant occurs. After hold falls, arbitration resumes with last_gnt unchanged.
- Reset mid-operation: an accepted but not yet captured write is dropped (rf_reg_write forced 0). A requester left waiting must re-present its request after reset releases.
- X on addr/data of a non-requesting port has no effect on any output.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W=32, ADDR_W=2, NREG=4;
  - localparams REQ_ALU=0, REQ_LOAD=1 for requester indices.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant logic plus the last_gnt register, with a hold input.
- The top level adds the issue-stage registers and pending-mask decode, and connects to the existing registerFile instance.

Test Plan:
1. Reset held low 2 cycles then released, no requests -> all outputs 0, last_gnt=1. A first single req0 (addr0=2'b00, data0=32'hAFAFDEDE) gives gnt0=1, then rf_reg_write=1 one cycle later and wr_pending=4'b0001. A register file readback of reg 0 returns AFAFDEDE.
2. req0 (addr 01, 32'hAFAFDDDD) and req1 (addr 10, 32'hCCCCDDDD) both held continuously:
   - grants alternate, gnt0 first, then gnt1;
   - rf_write_reg sequence is 01, 10 on consecutive cycles;
   - both registers read back correctly.
3. Both requesters target addr 11, req0 data 32'hBBBBBBBB, req1 data 32'h12345678, starting with last_gnt=1 -> req0 is written first, then req1. Reg 3 finally reads 32'h12345678.
4. hold=1 with both requests pending for 3 cycles -> gnt0=gnt1=0, rf_reg_write=0 after any in-flight write drains. After hold is released, the grant goes to the requester != last_gnt.
5. Reset asserted in the cycle after an accept (rf_reg_write=1) -> rf_reg_write drops to 0 asynchronously. The target register keeps its old value, and wr_pending=0.
6. Single requester streaming 4 back-to-back writes (addr 00..11) -> gnt1 high every cycle, rf_reg_write high for 4 consecutive cycles with no bubbles, and wr_pending walks 0001→0010→0100→1000.
